// File: rtl/devil_pkg.sv
// Shared definitions for the devil campaign sequencer: devil FSM state codes,
// control-register bit positions, table field codes and sequencer states.
package devil_pkg;

  typedef enum logic [3:0] {
    DEVIL_IDLE        = 4'd0,
    DEVIL_OSH         = 4'd1,
    DEVIL_CON         = 4'd2,
    DEVIL_EN          = 4'd3,
    DEVIL_READ        = 4'd4,
    DEVIL_DELAY       = 4'd5,
    DEVIL_WRITE       = 4'd6,
    DEVIL_REPLY       = 4'd7,
    DEVIL_DUMMY_REPLY = 4'd8
  } devil_state_e;

  localparam int CTRL_TEST_LSB  = 1;
  localparam int CTRL_TEST_MSB  = 4;
  localparam int CTRL_FUNC_LSB  = 5;
  localparam int CTRL_FUNC_MSB  = 8;
  localparam int CTRL_AC_FILT   = 14;
  localparam int CTRL_ADDR_FILT = 15;
  localparam int CTRL_OSH_EN    = 16;
  localparam int CTRL_CON_EN    = 17;

  typedef enum logic [2:0] {
    CFG_CONTROL   = 3'd0,
    CFG_DELAY     = 3'd1,
    CFG_ACSNOOP   = 3'd2,
    CFG_BASE_ADDR = 3'd3,
    CFG_ADDR_SIZE = 3'd4
  } cfg_field_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } seq_state_e;

  // A campaign counts as busy from the first load until it reaches S_DONE.
  function automatic logic seq_active(input seq_state_e s);
    return (s == S_LOAD) || (s == S_ARM) || (s == S_WAIT) || (s == S_GAP);
  endfunction

  function automatic logic seq_requesting(input seq_state_e s);
    return (s == S_ARM) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/devil_seq_table.sv
// Campaign configuration table: DEPTH entries of five config words, one
// synchronous write port (word-granular) and one combinational read port.
module devil_seq_table
  import devil_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [2:0]    field_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] ridx_i,
  output logic [DW-1:0] rd_control_o,
  output logic [DW-1:0] rd_delay_o,
  output logic [DW-1:0] rd_acsnoop_o,
  output logic [DW-1:0] rd_base_addr_o,
  output logic [DW-1:0] rd_addr_size_o
);

  logic [DW-1:0] control_q   [DEPTH];
  logic [DW-1:0] delay_q     [DEPTH];
  logic [DW-1:0] acsnoop_q   [DEPTH];
  logic [DW-1:0] base_addr_q [DEPTH];
  logic [DW-1:0] addr_size_q [DEPTH];

  // Field codes 5..7 are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        control_q[i]   <= '0;
        delay_q[i]     <= '0;
        acsnoop_q[i]   <= '0;
        base_addr_q[i] <= '0;
        addr_size_q[i] <= '0;
      end
    end else if (we_i) begin
      case (field_i)
        CFG_CONTROL:   control_q[widx_i]   <= wdata_i;
        CFG_DELAY:     delay_q[widx_i]     <= wdata_i;
        CFG_ACSNOOP:   acsnoop_q[widx_i]   <= wdata_i;
        CFG_BASE_ADDR: base_addr_q[widx_i] <= wdata_i;
        CFG_ADDR_SIZE: addr_size_q[widx_i] <= wdata_i;
        default: ;
      endcase
    end
  end

  assign rd_control_o   = control_q[ridx_i];
  assign rd_delay_o     = delay_q[ridx_i];
  assign rd_acsnoop_o   = acsnoop_q[ridx_i];
  assign rd_base_addr_o = base_addr_q[ridx_i];
  assign rd_addr_size_o = addr_size_q[ridx_i];

endmodule

// File: rtl/devil_campaign_seq.sv
// Steps through a table of devil_in_fpga test configurations, arming the snoop
// FSM per entry. Optional per-entry watchdog: define DEVIL_SEQ_TIMEOUT_EN.
module devil_campaign_seq
  import devil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int DEPTH              = 8,
  parameter int CNT_W              = 16,
  localparam int IW                = $clog2(DEPTH)
) (
  input  logic                          ace_aclk,
  input  logic                          ace_aresetn,
  input  logic                          i_cfg_we,
  input  logic [IW-1:0]                 i_cfg_idx,
  input  logic [2:0]                    i_cfg_field,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] i_cfg_wdata,
  input  logic                          i_start,
  input  logic [IW:0]                   i_num_entries,
  input  logic                          i_loop,
  input  logic                          i_abort,
  input  logic [3:0]                    i_fsm_devil_state,
  input  logic                          i_devil_end,
`ifdef DEVIL_SEQ_TIMEOUT_EN
  input  logic [15:0]                   i_timeout_cycles,
  output logic                          o_timeout,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_control_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_delay_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_acsnoop_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_base_addr_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0] o_addr_size_reg,
  output logic                          o_devil_req,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [IW-1:0]                 o_cur_idx,
  output logic [CNT_W-1:0]              o_done_cnt
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [IW-1:0]    IDX_ONE = IW'(1);
  localparam logic [IW:0]      NUM_ONE = (IW + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Drops OSH_EN/CON_EN so the devil cannot re-arm on stale settings.
  function automatic logic [DW-1:0] ctrl_disarm(input logic [DW-1:0] ctrl);
    logic [DW-1:0] r;
    r = ctrl;
    r[CTRL_OSH_EN] = 1'b0;
    r[CTRL_CON_EN] = 1'b0;
    return r;
  endfunction

  seq_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, cur_idx_q, cur_idx_d;
  logic [IW:0]      num_q, num_d;
  logic             loop_q, loop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, req_q, req_d;
  logic [DW-1:0]    ctrl_q, ctrl_d, dly_q, dly_d, acs_q, acs_d;
  logic [DW-1:0]    base_q, base_d, size_q, size_d;

  logic [DW-1:0] tbl_ctrl_s, tbl_dly_s, tbl_acs_s, tbl_base_s, tbl_size_s;
  logic          dev_idle_s, start_ok_s, last_s, load_s, end_ok_s;
  logic          gap_adv_s, tmo_hit_s, tmo_fire_s, enter_done_s, disarm_s;

  devil_seq_table #(.DEPTH(DEPTH), .DW(DW)) u_table (
    .clk            (ace_aclk),
    .rst_n          (ace_aresetn),
    .we_i           (i_cfg_we),
    .widx_i         (i_cfg_idx),
    .field_i        (i_cfg_field),
    .wdata_i        (i_cfg_wdata),
    .ridx_i         (idx_q),
    .rd_control_o   (tbl_ctrl_s),
    .rd_delay_o     (tbl_dly_s),
    .rd_acsnoop_o   (tbl_acs_s),
    .rd_base_addr_o (tbl_base_s),
    .rd_addr_size_o (tbl_size_s)
  );

  assign dev_idle_s = (i_fsm_devil_state == DEVIL_IDLE);
  assign start_ok_s = (state_q == S_IDLE) && i_start && !i_abort;
  assign last_s     = ({1'b0, idx_q} == (num_q - NUM_ONE));
  assign load_s     = (state_q == S_LOAD) && !i_abort;
  assign end_ok_s   = (state_q == S_WAIT) && i_devil_end && !i_abort;
  assign gap_adv_s  = (state_q == S_GAP) && dev_idle_s && !i_abort;
  assign tmo_fire_s = tmo_hit_s && !i_abort &&
                      (((state_q == S_ARM) && dev_idle_s) ||
                       ((state_q == S_WAIT) && !i_devil_end));

`ifdef DEVIL_SEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;

  assign tmo_hit_s = (i_timeout_cycles != 16'd0) && seq_requesting(state_q) &&
                     ((tmo_cnt_q + 16'd1) == i_timeout_cycles);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    if (state_q == S_LOAD) begin
      tmo_cnt_d = 16'd0;
    end else if (seq_requesting(state_q)) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    if (start_ok_s) begin
      timeout_d = 1'b0;
    end else if (tmo_fire_s) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      tmo_cnt_q <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign tmo_hit_s = 1'b0;
`endif

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort overrides every transition, including a start or end in the same cycle.
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = (i_num_entries != '0) ? S_LOAD : S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: state_d = S_ARM;
        S_ARM: begin
          if (!dev_idle_s) begin
            state_d = S_WAIT;
          end else if (tmo_fire_s) begin
            state_d = S_GAP;
          end else begin
            state_d = S_ARM;
          end
        end
        S_WAIT: begin
          if (i_devil_end || tmo_fire_s) begin
            state_d = S_GAP;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_GAP: begin
          if (!dev_idle_s) begin
            state_d = S_GAP;
          end else if (last_s && !loop_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign enter_done_s = (state_d == S_DONE) && (state_q != S_DONE);
  assign disarm_s     = i_abort || tmo_fire_s || enter_done_s;

  always_comb begin
    num_d  = num_q;
    loop_d = loop_q;
    if (start_ok_s) begin
      idx_d  = '0;
      num_d  = i_num_entries;
      loop_d = i_loop;
    end else if (gap_adv_s) begin
      if (!last_s) begin
        idx_d = idx_q + IDX_ONE;
      end else if (loop_q) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q;
      end
    end else begin
      idx_d = idx_q;
    end

    if (start_ok_s) begin
      cnt_d = '0;
    end else if (end_ok_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    cur_idx_d = cur_idx_q;
    ctrl_d    = ctrl_q;
    dly_d     = dly_q;
    acs_d     = acs_q;
    base_d    = base_q;
    size_d    = size_q;
    if (load_s) begin
      cur_idx_d = idx_q;
      ctrl_d    = tbl_ctrl_s;
      dly_d     = tbl_dly_s;
      acs_d     = tbl_acs_s;
      base_d    = tbl_base_s;
      size_d    = tbl_size_s;
    end else if (disarm_s) begin
      ctrl_d = ctrl_disarm(ctrl_q);
    end else begin
      ctrl_d = ctrl_q;
    end

    busy_d = seq_active(state_d);
    req_d  = seq_requesting(state_d);
    done_d = (state_q == S_DONE) && !i_abort;
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      idx_q     <= '0;
      num_q     <= '0;
      loop_q    <= 1'b0;
      cnt_q     <= '0;
      cur_idx_q <= '0;
      ctrl_q    <= '0;
      dly_q     <= '0;
      acs_q     <= '0;
      base_q    <= '0;
      size_q    <= '0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      num_q     <= num_d;
      loop_q    <= loop_d;
      cnt_q     <= cnt_d;
      cur_idx_q <= cur_idx_d;
      ctrl_q    <= ctrl_d;
      dly_q     <= dly_d;
      acs_q     <= acs_d;
      base_q    <= base_d;
      size_q    <= size_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
      done_q    <= done_d;
    end
  end

  assign o_control_reg   = ctrl_q;
  assign o_delay_reg     = dly_q;
  assign o_acsnoop_reg   = acs_q;
  assign o_base_addr_reg = base_q;
  assign o_addr_size_reg = size_q;
  assign o_devil_req     = req_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_cur_idx       = cur_idx_q;
  assign o_done_cnt      = cnt_q;

endmodule
